// File: rtl/alu_muldiv.sv
// ALU with an iterative multiply/divide unit and architectural HI/LO registers.
// Single-cycle ops finish in IDLE; MUL/DIV process one bit per RUN cycle.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       oper,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam int HW = WIDTH / 2;
  localparam logic [WIDTH-1:0]   ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE2    = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [CW-1:0]      CNT_ZERO = CW'(0);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SL   = 4'd7;
  localparam logic [3:0] OP_SR   = 4'd8;
  localparam logic [3:0] OP_LUI  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_DIV  = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12;
  localparam logic [3:0] OP_MFLO = 4'd13;
  localparam logic [3:0] OP_MTHI = 4'd14;
  localparam logic [3:0] OP_MTLO = 4'd15;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t             state_r;
  logic [CW-1:0]      cnt_r;
  logic               is_div_r;
  logic               qneg_r;
  logic               rneg_r;
  logic [WIDTH-1:0]   opnd_r;
  logic [2*WIDTH-1:0] acc_r;

  logic               accept_s;
  logic               start_s;
  logic               lt_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   alu_s;
  logic signed [WIDTH-1:0] sra_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] prod_s;

  assign in_ready = (state_r == IDLE) && !flush;
  assign accept_s = in_valid && in_ready;
  // A zero divisor is answered immediately instead of iterating.
  assign start_s  = (oper == OP_MUL) || ((oper == OP_DIV) && (b != ZERO));
  assign sra_s    = $signed(b) >>> a[SHW-1:0];

  // Operand signs and magnitudes feeding the iterative unit
  always_comb begin
    a_neg_s = sign & a[WIDTH-1];
    b_neg_s = sign & b[WIDTH-1];
    if (a_neg_s) a_mag_s = ~a + ONE;
    else         a_mag_s = a;
    if (b_neg_s) b_mag_s = ~b + ONE;
    else         b_mag_s = b;
  end

  // Single-cycle ALU datapath
  always_comb begin
    if (sign) lt_s = $signed(a) < $signed(b);
    else      lt_s = a < b;
    case (oper)
      OP_ADD:  alu_s = a + b;
      OP_SUB:  alu_s = a - b;
      OP_SLT:  alu_s = {{(WIDTH-1){1'b0}}, lt_s};
      OP_AND:  alu_s = a & b;
      OP_OR:   alu_s = a | b;
      OP_XOR:  alu_s = a ^ b;
      OP_NOR:  alu_s = ~(a | b);
      OP_SL:   alu_s = b << a[SHW-1:0];
      OP_SR:   alu_s = sign ? sra_s : (b >> a[SHW-1:0]);
      OP_LUI:  alu_s = {b[WIDTH-1:HW], {HW{1'b0}}};
      OP_MFHI: alu_s = hi;
      OP_MFLO: alu_s = lo;
      OP_MTHI: alu_s = a;
      OP_MTLO: alu_s = a;
      default: alu_s = ZERO;
    endcase
  end

  // One shift-add (MUL) or restoring-subtract (DIV) step; acc holds {upper, lower}
  always_comb begin
    sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO});
    diff_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
    if (!is_div_r)         acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    else if (!diff_s[WIDTH]) acc_next_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    else                   acc_next_s = {acc_r[2*WIDTH-2:0], 1'b0};
  end

  // Sign fix-up of the final step's product, quotient and remainder
  always_comb begin
    if (qneg_r) prod_s = ~acc_next_s + ONE2;
    else        prod_s = acc_next_s;
    if (qneg_r) quo_s = ~acc_next_s[WIDTH-1:0] + ONE;
    else        quo_s = acc_next_s[WIDTH-1:0];
    if (rneg_r) rem_s = ~acc_next_s[2*WIDTH-1:WIDTH] + ONE;
    else        rem_s = acc_next_s[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered result, flags and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      is_div_r  <= 1'b0;
      qneg_r    <= 1'b0;
      rneg_r    <= 1'b0;
      opnd_r    <= ZERO;
      acc_r     <= {2*WIDTH{1'b0}};
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      result    <= ZERO;
      hi        <= ZERO;
      lo        <= ZERO;
    end else begin
      out_valid <= 1'b0;
      div_zero  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (start_s) begin
              state_r  <= RUN;
              cnt_r    <= CNT_ZERO;
              is_div_r <= (oper == OP_DIV);
              qneg_r   <= a_neg_s ^ b_neg_s;
              rneg_r   <= a_neg_s;
              if (oper == OP_DIV) begin
                opnd_r <= b_mag_s;
                acc_r  <= {ZERO, a_mag_s};
              end else begin
                opnd_r <= a_mag_s;
                acc_r  <= {ZERO, b_mag_s};
              end
            end else if (oper == OP_DIV) begin
              out_valid <= 1'b1;
              div_zero  <= 1'b1;
              hi        <= a;
              lo        <= ONES;
              result    <= ONES;
            end else begin
              out_valid <= 1'b1;
              result    <= alu_s;
              if (oper == OP_MTHI) hi <= a;
              if (oper == OP_MTLO) lo <= a;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
          end else begin
            acc_r <= acc_next_s;
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == LAST) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              if (is_div_r) begin
                hi     <= rem_s;
                lo     <= quo_s;
                result <= quo_s;
              end else begin
                hi     <= prod_s[2*WIDTH-1:WIDTH];
                lo     <= prod_s[WIDTH-1:0];
                result <= prod_s[WIDTH-1:0];
              end
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed table, random ops vs. an
// arithmetic reference model, and hand sequences for flush/reset/back-to-back.
module tb_alu_muldiv;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLT = 4'd2, AND_ = 4'd3, OR_ = 4'd4;
  localparam logic [3:0] XOR_ = 4'd5, NOR_ = 4'd6, SL = 4'd7, SR = 4'd8, LUI = 4'd9;
  localparam logic [3:0] MUL = 4'd10, DIV = 4'd11, MFHI = 4'd12, MFLO = 4'd13;
  localparam logic [3:0] MTHI = 4'd14, MTLO = 4'd15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, sign = 1'b0, flush = 1'b0;
  logic [3:0]  oper = 4'd0;
  logic [31:0] a = 32'd0, b = 32'd0, result, hi, lo;
  logic        out_valid, div_zero;

  logic        in_valid16 = 1'b0, in_ready16, sign16 = 1'b0, flush16 = 1'b0;
  logic [3:0]  oper16 = 4'd0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0, result16, hi16, lo16;
  logic        out_valid16, div_zero16;

  int tests = 0;
  int fails = 0;
  logic [31:0] mh = 32'd0, ml = 32'd0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .oper(oper), .sign(sign), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .result(result), .div_zero(div_zero), .hi(hi), .lo(lo));

  alu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .oper(oper16), .sign(sign16), .a(a16), .b(b16), .flush(flush16),
    .out_valid(out_valid16), .result(result16), .div_zero(div_zero16), .hi(hi16), .lo(lo16));

  typedef struct {
    logic [3:0]  op;
    logic        s;
    logic [31:0] av, bv, r, h, l;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t tbl [24];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [3:0] op, input logic s, input logic [31:0] av, bv,
                       output logic [31:0] r, output logic dz, output int lat);
    logic [63:0] p;
    longint sa, sb, q, rm;
    int n;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    n = int'(av[4:0]);
    dz = 1'b0;
    lat = 1;
    r = 32'd0;
    case (op)
      ADD:  r = av + bv;
      SUB:  r = av - bv;
      SLT:  r = s ? 32'(sa < sb) : 32'(av < bv);
      AND_: r = av & bv;
      OR_:  r = av | bv;
      XOR_: r = av ^ bv;
      NOR_: r = ~(av | bv);
      SL:   r = bv << n;
      SR: begin
        r = bv >> n;
        if (s && bv[31]) r = r | ~(32'hFFFFFFFF >> n);
      end
      LUI:  r = {bv[31:16], 16'h0000};
      MUL: begin
        if (s) p = 64'(sa * sb);
        else   p = 64'(av) * 64'(bv);
        mh = p[63:32]; ml = p[31:0]; r = ml; lat = 33;
      end
      DIV: begin
        if (bv == 32'd0) begin
          dz = 1'b1; mh = av; ml = 32'hFFFFFFFF; r = ml;
        end else begin
          if (s) begin q = sa / sb; rm = sa % sb; end
          else begin q = longint'(av) / longint'(bv); rm = longint'(av) % longint'(bv); end
          ml = 32'(q); mh = 32'(rm); r = ml; lat = 33;
        end
      end
      MFHI: r = mh;
      MFLO: r = ml;
      MTHI: begin r = av; mh = av; end
      MTLO: begin r = av; ml = av; end
      default: r = 32'd0;
    endcase
  endtask

  // Issue one op (called #1 after an edge) and wait, bounded, for out_valid.
  task automatic run_op(input logic [3:0] op, input logic s, input logic [31:0] av, bv,
                        output logic [31:0] r, output logic dz, output int lat);
    logic [31:0] tmp;
    oper = op; sign = s; a = av; b = bv; in_valid = 1'b1;
    chk("ready_before_issue", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    tmp = $urandom; a = $urandom; b = $urandom; sign = tmp[0];
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk("ready_low_busy", in_ready, 1'b0);
      chk("dz_low_no_valid", div_zero, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    r = result; dz = div_zero;
    if (lat > 1) begin
      chk("ready_low_done", in_ready, 1'b0);
      @(posedge clk); #1;
      chk("valid_single_pulse", out_valid, 1'b0);
    end
  endtask

  task automatic step(input logic [3:0] op, input logic s, input logic [31:0] av, bv,
                      input string tag);
    logic [31:0] er, r;
    logic edz, dz;
    int elat, lat;
    model(op, s, av, bv, er, edz, elat);
    run_op(op, s, av, bv, r, dz, lat);
    chk({tag, "_result"}, r, er);
    chk({tag, "_divzero"}, dz, edz);
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_hi"}, hi, mh);
    chk({tag, "_lo"}, lo, ml);
  endtask

  task automatic run16(input logic [3:0] op, input logic s, input logic [15:0] av, bv,
                       output logic [15:0] r, output int lat);
    oper16 = op; sign16 = s; a16 = av; b16 = bv; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result16;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [15:0] r16;
    logic dz, seen;
    int lat;
    logic [31:0] tmp;

    tbl[0]  = '{ADD,  1'b0, 32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0,      32'h0,        1'b0, 1};
    tbl[1]  = '{SUB,  1'b0, 32'h0,        32'h1,        32'hFFFFFFFF, 32'h0,      32'h0,        1'b0, 1};
    tbl[2]  = '{SLT,  1'b1, 32'hFFFFFFFF, 32'h1,        32'h1,        32'h0,      32'h0,        1'b0, 1};
    tbl[3]  = '{SLT,  1'b0, 32'hFFFFFFFF, 32'h1,        32'h0,        32'h0,      32'h0,        1'b0, 1};
    tbl[4]  = '{AND_, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 32'h0,      32'h0,        1'b0, 1};
    tbl[5]  = '{OR_,  1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 32'h0,      32'h0,        1'b0, 1};
    tbl[6]  = '{XOR_, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 32'h0,      32'h0,        1'b0, 1};
    tbl[7]  = '{NOR_, 1'b0, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 32'h0,      32'h0,        1'b0, 1};
    tbl[8]  = '{SL,   1'b0, 32'h00000024, 32'h0000000F, 32'h000000F0, 32'h0,      32'h0,        1'b0, 1};
    tbl[9]  = '{SR,   1'b1, 32'h4,        32'hF0000000, 32'hFF000000, 32'h0,      32'h0,        1'b0, 1};
    tbl[10] = '{SR,   1'b0, 32'h4,        32'hF0000000, 32'h0F000000, 32'h0,      32'h0,        1'b0, 1};
    tbl[11] = '{LUI,  1'b0, 32'h0,        32'h12345678, 32'h12340000, 32'h0,      32'h0,        1'b0, 1};
    tbl[12] = '{MTHI, 1'b0, 32'hCAFE,     32'h0,        32'hCAFE,     32'hCAFE,   32'h0,        1'b0, 1};
    tbl[13] = '{MTLO, 1'b0, 32'hBEEF,     32'h0,        32'hBEEF,     32'hCAFE,   32'hBEEF,     1'b0, 1};
    tbl[14] = '{MFHI, 1'b0, 32'h0,        32'h0,        32'hCAFE,     32'hCAFE,   32'hBEEF,     1'b0, 1};
    tbl[15] = '{MFLO, 1'b0, 32'h0,        32'h0,        32'hBEEF,     32'hCAFE,   32'hBEEF,     1'b0, 1};
    tbl[16] = '{MUL,  1'b1, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33};
    tbl[17] = '{MUL,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    tbl[18] = '{DIV,  1'b1, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    tbl[19] = '{DIV,  1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        32'h0FFFFFFF, 1'b0, 33};
    tbl[20] = '{DIV,  1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        32'h80000000, 1'b0, 33};
    tbl[21] = '{DIV,  1'b0, 32'h5,        32'h0,        32'hFFFFFFFF, 32'h5,        32'hFFFFFFFF, 1'b1, 1};
    tbl[22] = '{DIV,  1'b1, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        32'hFFFFFFFD, 1'b0, 33};
    tbl[23] = '{MUL,  1'b1, 32'h80000000, 32'h80000000, 32'h0,        32'h40000000, 32'h0,        1'b0, 33};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_div_zero", div_zero, 1'b0);
    chk("reset16_hilo", {hi16, lo16}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", in_ready, 1'b1);

    // Directed table
    for (int i = 0; i < 24; i++) begin
      run_op(tbl[i].op, tbl[i].s, tbl[i].av, tbl[i].bv, r, dz, lat);
      chk($sformatf("tbl%0d_result", i), r, tbl[i].r);
      chk($sformatf("tbl%0d_divzero", i), dz, tbl[i].dz);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_hi", i), hi, tbl[i].h);
      chk($sformatf("tbl%0d_lo", i), lo, tbl[i].l);
    end
    mh = tbl[23].h;
    ml = tbl[23].l;

    // Randomized ops against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [3:0] op;
      logic [31:0] av, bv;
      tmp = $urandom;
      op = tmp[3:0];
      av = $urandom;
      bv = $urandom;
      if (tmp[6:4] == 3'd0) bv = 32'd0;
      if (tmp[6:4] == 3'd1) bv = {28'd0, tmp[11:8]};
      if (tmp[6:4] == 3'd2) begin av = 32'h80000000; bv = 32'hFFFFFFFF; end
      step(op, tmp[12], av, bv, $sformatf("rand%0d_op%0d", i, op));
    end

    // Flush during RUN cycle 10 discards the MUL and keeps HI
    step(MTHI, 1'b0, 32'h1234, 32'h0, "mthi");
    oper = MUL; sign = 1'b0; a = 32'd5; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    chk("flush_run_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_valid", seen, 1'b0);
    chk("flush_hi_kept", hi, 32'h1234);
    chk("flush_ready_idle", in_ready, 1'b1);
    step(MFHI, 1'b0, 32'h0, 32'h0, "mfhi_after_flush");

    // Flush in IDLE blocks accept
    oper = ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
    #1;
    chk("flush_idle_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    chk("flush_idle_no_valid", out_valid, 1'b0);
    flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;

    // Back-to-back single-cycle ops
    oper = ADD; sign = 1'b0; a = 32'd1; b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b0_valid", out_valid, 1'b1);
    chk("b2b0_result", result, 32'd3);
    a = 32'd10; b = 32'd20;
    @(posedge clk); #1;
    chk("b2b1_valid", out_valid, 1'b1);
    chk("b2b1_result", result, 32'd30);
    oper = SUB; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    chk("b2b2_valid", out_valid, 1'b1);
    chk("b2b2_result", result, 32'hFFFFFFFE);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_end_valid", out_valid, 1'b0);

    // Asynchronous reset at RUN cycle 5
    step(MTLO, 1'b0, 32'h55AA, 32'h0, "mtlo");
    oper = MUL; sign = 1'b1; a = 32'hFFFFFFFE; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_run_out_valid", out_valid, 1'b0);
    chk("rst_run_result", result, 32'd0);
    chk("rst_run_hi", hi, 32'd0);
    chk("rst_run_lo", lo, 32'd0);
    chk("rst_run_div_zero", div_zero, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mh = 32'd0; ml = 32'd0;
    chk("rst_release_ready", in_ready, 1'b1);
    seen = 1'b0;
    repeat (40) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_no_stale_valid", seen, 1'b0);
    step(ADD, 1'b0, 32'd40, 32'd2, "add_after_reset");
    step(MFHI, 1'b0, 32'd0, 32'd0, "mfhi_after_reset");

    // WIDTH=16 instance
    run16(MUL, 1'b1, 16'hFFFE, 16'h0003, r16, lat);
    chk("w16_mul_latency", lat, 17);
    chk("w16_mul_result", r16, 16'hFFFA);
    chk("w16_mul_hilo", {hi16, lo16}, 32'hFFFFFFFA);
    @(posedge clk); #1;
    run16(DIV, 1'b0, 16'hFFFF, 16'h0010, r16, lat);
    chk("w16_div_latency", lat, 17);
    chk("w16_div_hilo", {hi16, lo16}, 32'h000F0FFF);
    @(posedge clk); #1;
    run16(SR, 1'b1, 16'h0004, 16'hF000, r16, lat);
    chk("w16_sr_latency", lat, 1);
    chk("w16_sr_result", r16, 16'hFF00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
